// File: rtl/jacobi_angle_calc.sv
// rtl/jacobi_angle_calc.sv - Jacobi rotation angle: two-phase CORDIC giving cos/sin theta in Q1.14
module jacobi_angle_calc #(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 4,
  parameter int ITER      = 14,
  parameter int ANG_W     = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [ACC_WIDTH-1:0] a_pp,
  input  logic signed [ACC_WIDTH-1:0] a_qq,
  input  logic signed [ACC_WIDTH-1:0] a_pq,
  input  logic        [$clog2(N)-1:0] p_idx,
  input  logic        [$clog2(N)-1:0] q_idx,
  output logic                        busy,
  output logic                        done,
  output logic signed [15:0]          cos_theta,
  output logic signed [15:0]          sin_theta,
  output logic        [$clog2(N)-1:0] p_idx_out,
  output logic        [$clog2(N)-1:0] q_idx_out
);
  localparam int IW = $clog2(N);
  localparam int W  = ACC_WIDTH + 3;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int FB = 4;  // extra fraction bits carried through the rotation phase
  localparam logic signed [W-1:0] X_INIT = W'(9949 * (2 ** FB));
  localparam logic signed [W-1:0] RND    = W'(2 ** (FB - 1));
  localparam logic signed [W-1:0] SAT_HI = W'(16384);
  localparam logic signed [W-1:0] SAT_LO = -W'(16384);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_VEC, S_HALVE, S_ROT, S_OUT} state_t;

  state_t                      state, state_nx;
  logic signed [ACC_WIDTH-1:0] lat_pp, lat_qq, lat_pq;
  logic        [IW-1:0]        lat_p, lat_q;
  logic signed [W-1:0]         x, y;
  logic signed [ANG_W-1:0]     z;
  logic        [CW-1:0]        cnt;
  logic                        bypass;
  logic                        last_iter;

  // atan(2^-i) with 1 rad = 2^16
  function automatic logic signed [ANG_W-1:0] atan_rom(input logic [CW-1:0] i);
    case (int'(i))
      0:       atan_rom = ANG_W'(51472);
      1:       atan_rom = ANG_W'(30386);
      2:       atan_rom = ANG_W'(16055);
      3:       atan_rom = ANG_W'(8150);
      4:       atan_rom = ANG_W'(4091);
      5:       atan_rom = ANG_W'(2047);
      6:       atan_rom = ANG_W'(1024);
      7:       atan_rom = ANG_W'(512);
      8:       atan_rom = ANG_W'(256);
      9:       atan_rom = ANG_W'(128);
      default: atan_rom = ANG_W'(65536 >> int'(i));
    endcase
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [W-1:0] v);
    if (v > SAT_HI)      sat16 = 16'sd16384;
    else if (v < SAT_LO) sat16 = -16'sd16384;
    else                 sat16 = v[15:0];
  endfunction

  // PREP: fold d<0 into the right half-plane, then normalise so small inputs keep precision
  logic signed [W-1:0] d_ext, y_ext, d_n, y_n, y_mag, mag, x_prep, y_prep;
  int                  hb, sh;
  always_comb begin
    d_ext = {{3{lat_pp[ACC_WIDTH-1]}}, lat_pp} - {{3{lat_qq[ACC_WIDTH-1]}}, lat_qq};
    y_ext = {{2{lat_pq[ACC_WIDTH-1]}}, lat_pq, 1'b0};
    d_n   = d_ext[W-1] ? -d_ext : d_ext;
    y_n   = d_ext[W-1] ? -y_ext : y_ext;
    y_mag = y_n[W-1] ? -y_n : y_n;
    mag   = d_n | y_mag;
    hb    = 0;
    for (int b = 0; b < W; b++) begin
      if (mag[b]) hb = b;
    end
    sh     = (hb < ACC_WIDTH - 1) ? (ACC_WIDTH - 1 - hb) : 0;
    x_prep = d_n <<< sh;
    y_prep = y_n <<< sh;
  end

  logic signed [W-1:0]     x_sh, y_sh, x_rnd, y_rnd;
  logic signed [ANG_W-1:0] atan_i;
  always_comb begin
    x_sh   = x >>> cnt;
    y_sh   = y >>> cnt;
    atan_i = atan_rom(cnt);
    x_rnd  = (x + RND) >>> FB;
    y_rnd  = (y + RND) >>> FB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    last_iter = (cnt == CW'(ITER - 1));
    case (state)
      S_IDLE:  if (start) state_nx = S_PREP;
      S_PREP:  state_nx = S_VEC;
      S_VEC:   if (last_iter) state_nx = S_HALVE;
      S_HALVE: state_nx = S_ROT;
      S_ROT:   if (last_iter) state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_pp <= '0; lat_qq <= '0; lat_pq <= '0; lat_p <= '0; lat_q <= '0;
      x <= '0; y <= '0; z <= '0; cnt <= '0; bypass <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
      cos_theta <= '0; sin_theta <= '0; p_idx_out <= '0; q_idx_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          lat_pp <= a_pp; lat_qq <= a_qq; lat_pq <= a_pq;
          lat_p  <= p_idx; lat_q <= q_idx;
          busy   <= 1'b1;
        end
        S_PREP: begin
          x <= x_prep; y <= y_prep; z <= '0; cnt <= '0;
          bypass <= (lat_pq == '0);
        end
        S_VEC: begin
          if (!y[W-1]) begin
            x <= x + y_sh; y <= y - x_sh; z <= z + atan_i;
          end else begin
            x <= x - y_sh; y <= y + x_sh; z <= z - atan_i;
          end
          cnt <= cnt + 1'b1;
        end
        S_HALVE: begin
          z <= z >>> 1; x <= X_INIT; y <= '0; cnt <= '0;
        end
        S_ROT: begin
          if (!z[ANG_W-1]) begin
            x <= x - y_sh; y <= y + x_sh; z <= z - atan_i;
          end else begin
            x <= x + y_sh; y <= y - x_sh; z <= z + atan_i;
          end
          cnt <= cnt + 1'b1;
        end
        S_OUT: begin
          cos_theta <= bypass ? 16'sd16384 : sat16(x_rnd);
          sin_theta <= bypass ? 16'sd0     : sat16(y_rnd);
          p_idx_out <= lat_p;
          q_idx_out <= lat_q;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/jacobi_angle_calc.md
Name: jacobi_angle_calc

Overview:
- Upstream stage of the Jacobi rotation pair. For a symmetric matrix, takes the pivot elements a_pp, a_qq and a_pq.
- Computes the Jacobi rotation angle θ with an iterative two-phase CORDIC (vectoring, then rotation).
- Delivers cos θ / sin θ in signed Q1.14, ready for the left/right row and column rotation stages.
- Echoes the pivot indices p, q alongside the result.

Parameters:
- ACC_WIDTH, 32, width of the signed matrix elements.
- N, 4, matrix dimension; index width is $clog2(N).
- ITER, 14, number of CORDIC micro-rotations per phase.
- ANG_W, 20, signed angle accumulator width; 1 rad = 2^(ANG_W-4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only while idle.
- a_pp  in  ACC_WIDTH  signed diagonal element A[p][p].
- a_qq  in  ACC_WIDTH  signed diagonal element A[q][q].
- a_pq  in  ACC_WIDTH  signed off-diagonal element A[p][q].
- p_idx  in  $clog2(N)  pivot row index p.
- q_idx  in  $clog2(N)  pivot row index q.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; outputs valid from this cycle on.
- cos_theta  out  16  signed Q1.14 cos θ (16384 = 1.0).
- sin_theta  out  16  signed Q1.14 sin θ.
- p_idx_out  out  $clog2(N)  p latched at start.
- q_idx_out  out  $clog2(N)  q latched at start.

Behaviour:
- Reset (async, any state): FSM to IDLE; busy=0, done=0, cos_theta=0, sin_theta=0, idx outputs=0. An operation in flight is discarded and produces no done.
- Angle definition:
  - tan 2θ = 2·a_pq / (a_pp − a_qq), with θ restricted to [−π/4, π/4].
  - This choice zeroes A[p][q] under the downstream convention p' = c·p + s·q, q' = c·q − s·p.
- FSM states: IDLE → PREP → VEC → HALVE → ROT → OUT → IDLE.
- IDLE: start=1 latches the inputs and indices, sets busy=1, goes to PREP. start while busy is ignored with no queueing.
- PREP, 1 cycle:
  - d = a_pp − a_qq and y0 = 2·a_pq, both sign-extended to internal width ACC_WIDTH+3.
  - If d < 0, negate both d and y0, so x0 ≥ 0 and 2θ ∈ [−π/2, π/2] without pre-rotation.
  - Set z=0 and the iteration counter to 0.
  - If a_pq == 0, set a bypass flag.
- VEC, ITER cycles, vectoring mode:
  - Iteration i: if y ≥ 0, x += y>>>i, y −= x>>>i, z += atan(2^-i); otherwise the opposite signs.
  - atan values come from a constant ROM at ANG_W width.
  - x=y=0 (a_pp==a_qq and a_pq==0) falls under bypass.
- HALVE, 1 cycle: θ = z>>>1; x = 9949 (1/K in Q1.14); y = 0; counter cleared.
- ROT, ITER cycles, rotation mode on θ: direction is chosen by the sign of z, with the standard CORDIC update.
- OUT, 1 cycle:
  - Round x and y to 16 bits and saturate to [−16384, 16384].
  - Register cos_theta and sin_theta, or 16384 and 0 if bypass is set.
  - Pulse done=1, clear busy, return to IDLE.
- Latency is fixed, including bypass: done is high in the cycle after the 2·ITER+3rd rising edge following the start-sampling edge. With ITER=14 that is 31 edges.
- A new start is accepted in the cycle done is high (FSM is back in IDLE), so back-to-back throughput is one result per 2·ITER+4 cycles.
- Outputs hold their last value until the next done.
- Accuracy: |cos, sin error| ≤ 4 LSB versus ideal for all inputs, including full-scale ±2^(ACC_WIDTH−1) values, with no internal overflow.

Test Plan:
- a_pp=a_qq=100, a_pq=0, start → done after 31 edges; cos=16384, sin=0; busy high for exactly those cycles.
- a_pp=a_qq=1000, a_pq=500 → θ=π/4: cos=11585±4, sin=11585±4. a_pq=−500 → sin=−11585±4.
- a_pp=300, a_qq=100, a_pq=100 → θ=π/8: cos=15137±4, sin=6270±4.
- a_pp=100, a_qq=300, a_pq=100 (negative d) → θ=−π/8: cos=15137±4, sin=−6270±4.
- Extreme inputs: a_pq=−2^31, a_pp=a_qq=0 → cos=11585±4, sin=−11585±4. Also a_pp=2^31−1, a_qq=−2^31, a_pq=1 → cos=16384, sin=0 (±4). No wrap in either case.
- Control checks:
  - Start pulse mid-operation → ignored; result and indices still those of the first request.
  - Start in the done cycle → accepted, second done 32 edges later.
  - rst_n low mid-VEC → all outputs 0, no done; a fresh start afterwards completes correctly.
